rr_output_arbiter: RTL and testbench
====================================

Name: rr_output_arbiter

Overview:
- Per-output-port arbiter for the 5-port mesh router. Ports are indexed 0=local, 1=N, 2=E, 3=S, 4=W.
- Collects requests from all input ports for one output. Grants exactly one input using round-robin priority.
- Holds the grant for a whole wormhole packet, until its tail flit transfers.
- Drives a one-hot grant vector. The router's one-hot crossbar select logic consumes this vector, so grant bit i corresponds to select bit i.

Parameters:
- N_PORTS, 5, number of requesting input ports; grant and req width.
- MAX_FLITS, 16, maximum flits per packet before forced release; must be at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N_PORTS  req[i]=1: input i presents a flit for this output.
- tail  input  N_PORTS  tail[i]=1: flit presented by input i is a tail flit. Only meaningful when req[i]=1.
- out_ready  input  1  downstream buffer can accept a flit this cycle.
- grant  output  N_PORTS  one-hot grant, or all zero when no grant is held.
- grant_valid  output  1  a grant is currently held (OR of grant).
- xfer  output  1  a flit moves through the crossbar this cycle (combinational).
- ptr  output  3  current round-robin pointer, for debug.
- len_err  output  1  sticky flag: a packet exceeded MAX_FLITS.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE.
  - grant=0, grant_valid=0, ptr=0, flit counter=0, len_err=0.
  - xfer=0 follows from grant=0.
  - Asserting rst mid-packet drops the grant on the next edge. No flit is transferred in the reset cycle.
- States: IDLE and LOCKED.
- IDLE:
  - If req!=0, select the first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+N_PORTS-1 (mod N_PORTS).
  - Register grant=onehot(i) and go to LOCKED. Grant appears 1 cycle after req is seen.
  - If req=0, stay in IDLE with grant=0.
  - No flit transfers in IDLE.
- LOCKED, with owner o = index of grant:
  - xfer = req[o] & out_ready (combinational).
  - On xfer, increment the flit counter.
  - Owner dropping req: grant is held and no transfer happens; the wormhole stays reserved.
  - Requests from other inputs are ignored while LOCKED.
  - out_ready=0 stalls transfers; grant is held.
  - Release on xfer & tail[o]:
    - Next cycle: grant=0, state IDLE, ptr=(o+1) mod N_PORTS, counter=0.
    - A new grant is issued at the earliest one cycle after release, giving a 1-cycle bubble between packets.
  - Single-flit packet (head=tail): granted, transferred and released like any other packet.
  - Forced release on xfer when counter==MAX_FLITS-1 without tail:
    - Release as above and set len_err=1.
    - len_err clears only on rst.
- Pointer: updates only on release, never on grant, so a waiting requester is served within N_PORTS-1 packets.
- Width rules:
  - Counter width is clog2(MAX_FLITS).
  - ptr is compared mod N_PORTS; values at or above N_PORTS never occur.
- Invariant: grant is one-hot or zero in every cycle. A bench assertion checks this.

Test Plan:
- After rst, req=5'b00110 with ptr=0 -> next cycle grant=5'b00010. Three flits with out_ready=1, tail on the 3rd -> xfer high 3 cycles, grant=0 the cycle after, ptr=2.
- Continue with req=5'b00110 held after release -> one bubble cycle, then grant=5'b00100 (input 2). After its release, ptr=3 and the next grant is input 1 (wrap-around).
- Owner input 4 with out_ready toggling 1,0,0,1 and req[4] dropping for 2 cycles mid-packet -> grant=5'b10000 held throughout; xfer only when req[4]&out_ready; no other input granted.
- Single-flit packets from all 5 inputs simultaneously (req=5'b11111, tail=5'b11111) -> grants in order 0,1,2,3,4, each 2 cycles apart; ptr ends at 0.
- MAX_FLITS=4 and a 6-flit packet from input 3 -> forced release after the 4th xfer, len_err=1 and held. Remaining flits re-arbitrate as a new packet.
- rst asserted in the 2nd cycle of a LOCKED packet from input 1 -> next cycle grant=0, ptr=0, len_err=0, state IDLE. Arbitration resumes from ptr 0.

Source files
------------

// File: rtl/rr_output_arbiter.sv
// Round-robin per-output arbiter for the 5-port wormhole mesh router.
// Holds a one-hot grant for a whole packet; releases on tail or on length overflow.
module rr_output_arbiter #(
  parameter int N_PORTS   = 5,
  parameter int MAX_FLITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] grant,
  output logic               grant_valid,
  output logic               xfer,
  output logic [2:0]         ptr,
  output logic               len_err
);

  localparam int CNT_W = $clog2(MAX_FLITS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q;
  logic [N_PORTS-1:0] grant_q;
  logic [2:0]         ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               len_err_q;

  logic [N_PORTS-1:0] reqRot;
  logic [N_PORTS-1:0] pickRot;
  logic [N_PORTS-1:0] grant_d;
  logic [2:0]         ownerIdx;
  logic [2:0]         ptr_d;
  logic               ownerReq;
  logic               ownerTail;
  logic               lastFlit;
  logic               relXfer;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    reqRot  = N_PORTS'({req, req} >> ptr_q);
    pickRot = reqRot & (~reqRot + N_PORTS'(1));
    grant_d = N_PORTS'(({pickRot, pickRot} << ptr_q) >> N_PORTS);

    ownerIdx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q[i]) ownerIdx = 3'(i);
    end
    ptr_d = (ownerIdx == 3'(N_PORTS - 1)) ? 3'd0 : ownerIdx + 3'd1;

    ownerReq  = |(grant_q & req);
    ownerTail = |(grant_q & tail);
    lastFlit  = (cnt_q == CNT_W'(MAX_FLITS - 1));
    xfer      = (state_q == LOCKED) & ownerReq & out_ready & ~rst;
    relXfer   = xfer & (ownerTail | lastFlit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= grant_d;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // The pointer only moves on release, which bounds every waiter's latency.
          if (relXfer) begin
            grant_q <= '0;
            state_q <= IDLE;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            if (!ownerTail) len_err_q <= 1'b1;
          end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign ptr         = ptr_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed-vector bench for rr_output_arbiter with a queue-based scoreboard.
// Expected per-cycle outputs are queued by the driver and checked by an independent monitor.
module tb_rr_output_arbiter;

  localparam int NP   = 5;
  localparam int MAXF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req;
  logic [NP-1:0] tail;
  logic          outReady;
  logic [NP-1:0] grant;
  logic          grantValid;
  logic          xfer;
  logic [2:0]    ptr;
  logic          lenErr;

  typedef struct {
    int            id;
    logic [NP-1:0] grant;
    logic          xfer;
    logic [2:0]    ptr;
    logic          lenErr;
  } expect_t;

  expect_t expQ[$];
  int      compared   = 0;
  int      mismatched = 0;
  int      vecId      = 0;
  logic    checking   = 1'b0;

  rr_output_arbiter #(
    .N_PORTS  (NP),
    .MAX_FLITS(MAXF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .out_ready  (outReady),
    .grant      (grant),
    .grant_valid(grantValid),
    .xfer       (xfer),
    .ptr        (ptr),
    .len_err    (lenErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int id,
                             input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, id, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT should show during that cycle.
  task automatic applyStimulus(input logic r, input logic [NP-1:0] rq,
                               input logic [NP-1:0] tl, input logic rdy,
                               input logic [NP-1:0] eG, input logic eX,
                               input logic [2:0] eP, input logic eE);
    expect_t e;
    @(posedge clk);
    #1;
    rst      = r;
    req      = rq;
    tail     = tl;
    outReady = rdy;
    vecId++;
    e.id     = vecId;
    e.grant  = eG;
    e.xfer   = eX;
    e.ptr    = eP;
    e.lenErr = eE;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("grant",       e.id, 32'(grant),      32'(e.grant));
      checkOutput("xfer",        e.id, 32'(xfer),       32'(e.xfer));
      checkOutput("ptr",         e.id, 32'(ptr),        32'(e.ptr));
      checkOutput("len_err",     e.id, 32'(lenErr),     32'(e.lenErr));
      checkOutput("grant_valid", e.id, 32'(grantValid), 32'(|e.grant));
    end
    if (checking) checkOutput("grant_onehot0", vecId, 32'($onehot0(grant)), 32'd1);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    req      = '0;
    tail     = '0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    checking = 1'b1;

    // 3-flit packet from input 1, then input 2 after one bubble, then wrap to input 1.
    applyStimulus(0, 5'b00110, 5'b00000, 1, 5'b00000, 0, 3'd0, 0);
    applyStimulus(0, 5'b00110, 5'b00000, 1, 5'b00010, 1, 3'd0, 0);
    applyStimulus(0, 5'b00110, 5'b00000, 1, 5'b00010, 1, 3'd0, 0);
    applyStimulus(0, 5'b00110, 5'b00010, 1, 5'b00010, 1, 3'd0, 0);
    applyStimulus(0, 5'b00110, 5'b00000, 1, 5'b00000, 0, 3'd2, 0);
    applyStimulus(0, 5'b00110, 5'b00000, 1, 5'b00100, 1, 3'd2, 0);
    applyStimulus(0, 5'b00110, 5'b00100, 1, 5'b00100, 1, 3'd2, 0);
    applyStimulus(0, 5'b00110, 5'b00000, 1, 5'b00000, 0, 3'd3, 0);
    applyStimulus(0, 5'b00010, 5'b00010, 1, 5'b00010, 1, 3'd3, 0);
    applyStimulus(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd2, 0);

    // Input 4 owns the output through stalls and a dropped request; others are ignored.
    applyStimulus(0, 5'b10000, 5'b00000, 1, 5'b00000, 0, 3'd2, 0);
    applyStimulus(0, 5'b10001, 5'b00000, 1, 5'b10000, 1, 3'd2, 0);
    applyStimulus(0, 5'b10011, 5'b00000, 0, 5'b10000, 0, 3'd2, 0);
    applyStimulus(0, 5'b00011, 5'b00000, 0, 5'b10000, 0, 3'd2, 0);
    applyStimulus(0, 5'b00011, 5'b00000, 1, 5'b10000, 0, 3'd2, 0);
    applyStimulus(0, 5'b10001, 5'b10000, 1, 5'b10000, 1, 3'd2, 0);
    applyStimulus(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 0);

    // Single-flit packets from every input: served 0..4, two cycles apart.
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd0, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00001, 1, 3'd0, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd1, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00010, 1, 3'd1, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd2, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00100, 1, 3'd2, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd3, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b01000, 1, 3'd3, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b00000, 0, 3'd4, 0);
    applyStimulus(0, 5'b11111, 5'b11111, 1, 5'b10000, 1, 3'd4, 0);
    applyStimulus(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 0);

    // 6-flit packet from input 3 with MAX_FLITS=4: forced release, sticky len_err.
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b00000, 0, 3'd0, 0);
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3'd0, 0);
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3'd0, 0);
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3'd0, 0);
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3'd0, 0);
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b00000, 0, 3'd4, 1);
    applyStimulus(0, 5'b01000, 5'b00000, 1, 5'b01000, 1, 3'd4, 1);
    applyStimulus(0, 5'b01000, 5'b01000, 1, 5'b01000, 1, 3'd4, 1);
    applyStimulus(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd4, 1);

    // Reset in the second locked cycle of a packet from input 1.
    applyStimulus(0, 5'b00010, 5'b00000, 1, 5'b00000, 0, 3'd4, 1);
    applyStimulus(0, 5'b00010, 5'b00000, 1, 5'b00010, 1, 3'd4, 1);
    applyStimulus(1, 5'b00010, 5'b00000, 1, 5'b00010, 0, 3'd4, 1);
    applyStimulus(0, 5'b00010, 5'b00000, 1, 5'b00000, 0, 3'd0, 0);
    applyStimulus(0, 5'b00010, 5'b00010, 1, 5'b00010, 1, 3'd0, 0);
    applyStimulus(0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd2, 0);

    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
